// File: rtl/line_stream_feeder.sv
// Paced raster pixel feeder with credit-based line flow control and zero flush lines.
// Optional stall statistics output enabled by defining LINE_STREAM_FEEDER_STATS_EN.
module line_stream_feeder #(
    parameter int IMAGE_WIDTH      = 512,
    parameter int IMAGE_HEIGHT     = 512,
    parameter int NUM_LINE_BUFFERS = 4,
    parameter int FLUSH_LINES      = 2
) (
    input  logic                                clk,
    input  logic                                rstN,
    input  logic                                start,
    input  logic [7:0]                          s_pixel,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic                                line_consumed,
    output logic [7:0]                          pixel_out,
    output logic                                pixel_out_valid,
    output logic                                busy,
    output logic                                frame_done,
    output logic [$clog2(NUM_LINE_BUFFERS):0]   credits,
    output logic                                credit_err
`ifdef LINE_STREAM_FEEDER_STATS_EN
    ,
    output logic [31:0]                         stall_cycles
`endif
);

    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int FL_W  = (FLUSH_LINES > 0) ? $clog2(FLUSH_LINES + 1) : 1;
    localparam int CR_W  = $clog2(NUM_LINE_BUFFERS) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [FL_W-1:0]   r_flush_cnt;
    logic [CR_W-1:0]   r_credits;
    logic              r_credit_err;
    logic [7:0]        r_pixel;
    logic              r_valid;
    logic              r_done;

    logic w_col_first;
    logic w_col_last;
    logic w_row_last;
    logic w_flush_last;
    logic w_credits_full;
    logic w_can_go;
    logic w_stream_xfer;
    logic w_flush_emit;
    logic w_line_start;

    assign w_col_first    = (r_col == '0);
    assign w_col_last     = (r_col == COL_W'(IMAGE_WIDTH - 1));
    assign w_row_last     = (r_row == ROW_W'(IMAGE_HEIGHT - 1));
    assign w_flush_last   = (r_flush_cnt == FL_W'(FLUSH_LINES - 1));
    assign w_credits_full = (r_credits == CR_W'(NUM_LINE_BUFFERS));
    // A new line may only begin while a downstream buffer is free.
    assign w_can_go       = !w_col_first || (r_credits != '0);
    assign w_stream_xfer  = (r_state == S_STREAM) && s_valid && w_can_go;
    assign w_flush_emit   = (r_state == S_FLUSH) && w_can_go;
    assign w_line_start   = (w_stream_xfer || w_flush_emit) && w_col_first;

    assign s_ready         = (r_state == S_STREAM) && w_can_go;
    assign busy            = (r_state != S_IDLE);
    assign pixel_out       = r_pixel;
    assign pixel_out_valid = r_valid;
    assign frame_done      = r_done;
    assign credits         = r_credits;
    assign credit_err      = r_credit_err;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_flush_cnt  <= '0;
            r_credits    <= CR_W'(NUM_LINE_BUFFERS);
            r_credit_err <= 1'b0;
            r_pixel      <= 8'h00;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The cycle showing frame_done still ignores start.
                    if (start && !r_done) begin
                        r_state      <= S_STREAM;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_flush_cnt  <= '0;
                        r_credit_err <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (w_stream_xfer) begin
                        r_pixel <= s_pixel;
                        r_valid <= 1'b1;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row       <= '0;
                                r_flush_cnt <= '0;
                                r_state     <= (FLUSH_LINES == 0) ? S_DRAIN : S_FLUSH;
                            end else begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_flush_emit) begin
                        r_pixel <= 8'h00;
                        r_valid <= 1'b1;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_flush_last) begin
                                r_flush_cnt <= '0;
                                r_state     <= S_DRAIN;
                            end else begin
                                r_flush_cnt <= r_flush_cnt + FL_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_credits_full) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Placed after the IDLE clear so an over-return on the start cycle still flags.
            if (line_consumed && !w_line_start) begin
                if (w_credits_full) begin
                    r_credit_err <= 1'b1;
                end else begin
                    r_credits <= r_credits + CR_W'(1);
                end
            end else if (w_line_start && !line_consumed) begin
                r_credits <= r_credits - CR_W'(1);
            end
        end
    end

`ifdef LINE_STREAM_FEEDER_STATS_EN
    logic [31:0] r_stall;
    logic        w_stalled;

    assign w_stalled    = ((r_state == S_STREAM) || (r_state == S_FLUSH)) && !w_can_go;
    assign stall_cycles = r_stall;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_stall <= '0;
        end else if ((r_state == S_IDLE) && start && !r_done) begin
            r_stall <= '0;
        end else if (w_stalled && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/line_stream_feeder.md
Name: line_stream_feeder

Overview:
- Source-side driver of the 8-bit pixel stream consumed by the line-buffer window loader.
- Accepts raster pixels from an upstream ready/valid source, one frame per start pulse.
- Emits a paced pixel_out/pixel_out_valid stream with credit-based line flow control, so the downstream 4-line buffer set never overruns.
- Appends zero flush lines so the last image rows drain through the window pipeline.

Parameters:
IMAGE_WIDTH, 512, pixels per line
IMAGE_HEIGHT, 512, lines per frame
NUM_LINE_BUFFERS, 4, downstream line buffers = maximum lines in flight = initial credits
FLUSH_LINES, 2, zero-valued lines appended after the last image line

Ports:
clk  in  1  clock
rstN  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begins a frame; ignored unless IDLE
s_pixel  in  8  upstream pixel
s_valid  in  1  upstream pixel valid
s_ready  out  1  feeder accepts s_pixel this cycle
line_consumed  in  1  one-cycle pulse from downstream: one line buffer freed
pixel_out  out  8  pixel to loader
pixel_out_valid  out  1  pixel_out valid (no backpressure downstream)
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at end of frame
credits  out  $clog2(NUM_LINE_BUFFERS)+1  free downstream lines
credit_err  out  1  sticky: line_consumed received while credits == NUM_LINE_BUFFERS

Behaviour:
- Interface: reset rstN, synchronous, active-low; clock clk.
- Reset values:
  - s_ready, pixel_out_valid, busy, frame_done, credit_err = 0.
  - pixel_out = 0.
  - credits = NUM_LINE_BUFFERS.
  - col = row = 0; state IDLE.
- FSM states: IDLE, STREAM, FLUSH, DRAIN.
  - IDLE -> STREAM on start. Clears col, row and credit_err; credits are not reset.
  - STREAM:
    - s_ready = (col != 0) || (credits != 0).
    - On a transfer (s_valid && s_ready):
      - Capture s_pixel into pixel_out; pixel_out_valid = 1 next cycle (latency 1).
      - col increments, wrapping at IMAGE_WIDTH-1, and row increments on the wrap.
    - A transfer at col == 0 consumes one credit.
    - Transfer at col == IMAGE_WIDTH-1, row == IMAGE_HEIGHT-1 -> FLUSH, or -> DRAIN if FLUSH_LINES == 0.
  - FLUSH:
    - s_ready = 0.
    - Emits FLUSH_LINES × IMAGE_WIDTH pixels of value 0, one per cycle.
    - Same credit gating as STREAM: a line starts only when credits != 0; each line start consumes one credit.
    - The last flush pixel -> DRAIN.
  - DRAIN:
    - s_ready = 0; no output.
    - Waits until credits == NUM_LINE_BUFFERS, then pulses frame_done for 1 cycle -> IDLE.
- pixel_out_valid is 0 in every cycle with no transfer or flush emission. pixel_out holds its last value when not valid.
- Credits:
  - Line start alone: credits-1. line_consumed alone: credits+1. Both in the same cycle: unchanged.
  - line_consumed at credits == NUM_LINE_BUFFERS (and no simultaneous line start): credits unchanged, credit_err set. It stays set until the next start or reset.
  - Credits never go below 0 by construction; line start is blocked at 0.
  - line_consumed is honoured in every state, including IDLE.
- start while busy is ignored. start in the same cycle as the frame_done pulse is ignored; the feeder is in IDLE the next cycle.
- Reset mid-frame returns all state to reset values in the next cycle. Partially sent lines are abandoned.
- Counter widths: col is $clog2(IMAGE_WIDTH) bits; row is $clog2(IMAGE_HEIGHT) bits; the flush line counter is $clog2(FLUSH_LINES+1) bits.

Optional Feature:
- Macro: LINE_STREAM_FEEDER_STATS_EN.
- Defined: adds output stall_cycles (32 bits), reset 0, cleared on start.
  - Increments each cycle in STREAM or FLUSH where the next line cannot start because credits == 0 at col == 0.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Bench parameters for all scenarios: IMAGE_WIDTH=8, IMAGE_HEIGHT=6, NUM_LINE_BUFFERS=4, FLUSH_LINES=2.
- Basic stream:
  - Stimulus: start; s_valid held high with s_pixel = 1..48; never pulse line_consumed.
  - Response: exactly 32 pixels (1..32) emitted, one cycle after each transfer. Then s_ready = 0 at col 0 and credits = 0.
- Credit return:
  - Stimulus: from the stalled state, pulse line_consumed once.
  - Response: credits = 1, then 0 on the next line start. Pixels 33..40 are emitted and the feeder stalls again.
- Full frame:
  - Stimulus: return one credit each time the feeder stalls.
  - Response: 48 image pixels, then 16 zeros. After enough consumes to reach credits = 4, a single frame_done pulse; busy = 0.
- Simultaneous events:
  - Stimulus: line_consumed in the same cycle as a col-0 transfer at credits = 1.
  - Response: credits stays 1. Separately, line_consumed at credits = 4 -> credit_err = 1, credits = 4.
- Reset mid-frame:
  - Stimulus: assert rstN = 0 at row 2, col 3.
  - Response: next cycle pixel_out_valid = 0, s_ready = 0, busy = 0, credits = 4. A new start begins at pixel 1 of the source.
- Stats (macro defined):
  - Stimulus: hold credits at 0 for 10 cycles in STREAM.
  - Response: stall_cycles = 10; it clears to 0 on the next start.
